// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, S-box table, round constants and the
// key-schedule FSM states used by the forward and inverse key schedulers.
package aes_pkg;

   localparam int AES_NR = 10;

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} ks_state_e;

   // Entry 0 is the most significant byte, so SBOX[x] reads naturally.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [31:0] rcon(input logic [3:0] r);
      logic [7:0] b;
      case (r)
         4'd1:    b = 8'h01;
         4'd2:    b = 8'h02;
         4'd3:    b = 8'h04;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h10;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         4'd8:    b = 8'h80;
         4'd9:    b = 8'h1b;
         4'd10:   b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h000000};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, purely combinational table lookup.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = SBOX[din];

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: walks round keys 10 down to 0,
// one key per accepted handshake on the key_valid/key_ready interface.
module inv_key_schedule
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [127:0] last_key,
   input  logic         key_ready,
   output logic         key_valid,
   output logic [127:0] rnd_key,
   output logic [3:0]   rnd_no,
   output logic         busy,
   output logic         done
);

   if (NUM_ROUNDS != AES_NR) begin : g_bad_nr
      $error("inv_key_schedule: only NUM_ROUNDS=10 (AES-128) is supported");
   end

   ks_state_e    state_q, state_d;
   logic         hs, load, step, done_d;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  p0, p1, p2, p3;
   logic [31:0]  rot, sub;
   logic [127:0] key_step;

   // Undo one forward expansion step, straight off the rnd_key register.
   assign {w0, w1, w2, w3} = rnd_key;
   assign p3  = w3 ^ w2;
   assign p2  = w2 ^ w1;
   assign p1  = w1 ^ w0;
   assign rot = {p3[23:0], p3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .din  (rot[8*i +: 8]),
         .dout (sub[8*i +: 8])
      );
   end

   assign p0       = w0 ^ sub ^ rcon(rnd_no);
   assign key_step = {p0, p1, p2, p3};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !abort) state_d = EMIT;
         EMIT:    if (abort || (hs && rnd_no == 4'd0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // abort masks the handshake so it always wins.
   always_comb begin
      busy      = (state_q != IDLE);
      key_valid = (state_q == EMIT);
      hs        = key_valid && key_ready && !abort;
      load      = (state_q == IDLE) && start && !abort;
      step      = hs && (rnd_no != 4'd0);
      done_d    = hs && (rnd_no == 4'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_key <= '0;
         rnd_no  <= '0;
         done    <= 1'b0;
      end else begin
         done <= done_d;
         if (load) begin
            rnd_key <= last_key;
            rnd_no  <= 4'(NUM_ROUNDS);
         end else if (step) begin
            rnd_key <= key_step;
            rnd_no  <= rnd_no - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 A.1 walk, backpressure, abort,
// async reset, start corner cases and a forward-schedule round trip.
module tb_inv_key_schedule;
   import aes_pkg::*;

   typedef logic [127:0] ks_t [0:10];

   localparam logic [7:0] RC [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, key_ready = 1'b0;
   logic [127:0] last_key = '0;
   logic         key_valid, busy, done;
   logic [127:0] rnd_key;
   logic [3:0]   rnd_no;
   int           n_vec = 0, n_err = 0;
   ks_t          fips, ks;

   inv_key_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .last_key  (last_key),
      .key_ready (key_ready),
      .key_valid (key_valid),
      .rnd_key   (rnd_key),
      .rnd_no    (rnd_no),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Forward AES-128 key expansion, independent reference for the round trip.
   task automatic expand(input logic [127:0] k0, output ks_t o);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = k0;
      o[0] = k0;
      for (int r = 1; r <= 10; r++) begin
         w0 = w0 ^ subw({w3[23:0], w3[31:24]}) ^ {RC[r], 24'h0};
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         o[r] = {w0, w1, w2, w3};
      end
   endtask

   task automatic kick(input logic [127:0] lk);
      last_key = lk;
      start    = 1'b1;
      cyc();
      start    = 1'b0;
      chk("kick_valid", 128'(key_valid), 128'(1));
      chk("kick_done",  128'(done), 128'(0));
   endtask

   // Consumes all 11 keys; returns positioned on the done cycle.
   task automatic drain(input ks_t exp, input bit bp, input bit poke);
      int got = 0, n = 1;
      bit hs;
      while (got < 11 && n < 400) begin
         key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke) begin
            start    = 1'($urandom_range(0, 1));
            last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         chk("valid", 128'(key_valid), 128'(1));
         chk("rnd_no", 128'(rnd_no), 128'(10 - got));
         chk("rnd_key", rnd_key, exp[10 - got]);
         chk("no_early_done", 128'(done), 128'(0));
         hs = key_ready;
         cyc();
         n++;
         if (hs) got++;
      end
      start     = 1'b0;
      key_ready = 1'b0;
      chk("keys_taken", 128'(got), 128'(11));
      chk("done_pulse", 128'(done), 128'(1));
      chk("end_valid", 128'(key_valid), 128'(0));
      chk("end_busy", 128'(busy), 128'(0));
      if (!bp) chk("latency", 128'(n), 128'(12));
   endtask

   task automatic idle_chk();
      cyc();
      chk("done_clear", 128'(done), 128'(0));
      chk("idle_busy", 128'(busy), 128'(0));
   endtask

   initial begin
      fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      // reset state
      #3;
      chk("rst_valid", 128'(key_valid), 128'(0));
      chk("rst_key", rnd_key, 128'(0));
      chk("rst_no", 128'(rnd_no), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      cyc();
      #2 rst = 1'b0;
      key_ready = 1'b1;
      cyc();
      chk("idle_no_start", 128'(key_valid), 128'(0));
      key_ready = 1'b0;

      // FIPS-197 A.1, ready tied high
      kick(fips[10]);
      drain(fips, 1'b0, 1'b0);
      idle_chk();

      // random backpressure
      kick(fips[10]);
      drain(fips, 1'b1, 1'b0);
      idle_chk();

      // abort at round 5
      kick(fips[10]);
      key_ready = 1'b1;
      for (int i = 0; i < 20 && rnd_no != 4'd5; i++) cyc();
      chk("abort_reach", 128'(rnd_no), 128'(5));
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("abort_valid", 128'(key_valid), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      chk("abort_hold_no", 128'(rnd_no), 128'(5));
      chk("abort_hold_key", rnd_key, fips[5]);
      cyc();
      chk("abort_idle", 128'(key_valid), 128'(0));
      key_ready = 1'b0;
      kick(fips[10]);
      drain(fips, 1'b0, 1'b0);
      idle_chk();

      // async reset mid-run at round 7
      kick(fips[10]);
      key_ready = 1'b1;
      for (int i = 0; i < 20 && rnd_no != 4'd7; i++) cyc();
      chk("rst_reach", 128'(rnd_no), 128'(7));
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 128'(key_valid), 128'(0));
      chk("arst_key", rnd_key, 128'(0));
      chk("arst_no", 128'(rnd_no), 128'(0));
      chk("arst_busy", 128'(busy), 128'(0));
      cyc();
      #3 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_idle", 128'(busy), 128'(0));
      end
      key_ready = 1'b0;
      kick(fips[10]);
      drain(fips, 1'b0, 1'b0);
      idle_chk();

      // start while busy ignored, then start in the done cycle
      kick(fips[10]);
      drain(fips, 1'b0, 1'b1);
      kick(fips[10]);
      chk("restart_no", 128'(rnd_no), 128'(10));
      drain(fips, 1'b0, 1'b0);
      idle_chk();

      // round trip against forward expansion
      for (int k = 0; k < 1000; k++) begin
         expand({$urandom(), $urandom(), $urandom(), $urandom()}, ks);
         kick(ks[10]);
         drain(ks, (k % 8) == 3, 1'b0);
         idle_chk();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
